// File: rtl/logicnet_pkg.sv
// Shared types and sizing helpers for the LogicNets runtime-programmable LUT layer.
package logicnet_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } lut_state_e;

    function automatic int table_depth(input int in_bits);
        return 32'sd1 << in_bits;
    endfunction

    function automatic int sel_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/logicnet_lut_layer_if.sv
// Lookup stream, table-write port and status of the LUT layer, bundled for port connection.
interface logicnet_lut_layer_if #(
    parameter int N_NEURONS = 8,
    parameter int IN_BITS   = 6,
    parameter int OUT_BITS  = 1
);
    import logicnet_pkg::*;

    localparam int NW = sel_width(N_NEURONS);

    logic                            in_valid;
    logic                            in_ready;
    logic [N_NEURONS*IN_BITS-1:0]    in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [N_NEURONS*OUT_BITS-1:0]   out_data;
    logic                            cfg_valid;
    logic                            cfg_ready;
    logic [NW-1:0]                   cfg_neuron;
    logic [IN_BITS-1:0]              cfg_addr;
    logic [OUT_BITS-1:0]             cfg_data;
    logic                            cfg_clear;
    logic                            busy;

    modport master (
        output in_valid, in_data, out_ready,
        output cfg_valid, cfg_neuron, cfg_addr, cfg_data, cfg_clear,
        input  in_ready, out_valid, out_data, cfg_ready, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        input  cfg_valid, cfg_neuron, cfg_addr, cfg_data, cfg_clear,
        output in_ready, out_valid, out_data, cfg_ready, busy
    );

endinterface

// File: rtl/logicnet_lut_ram.sv
// One neuron truth table: single write port, asynchronous read, storage without reset.
module logicnet_lut_ram
    import logicnet_pkg::*;
#(
    parameter int ADDR_BITS = 6,
    parameter int DATA_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    localparam int DEPTH = table_depth(ADDR_BITS);

    (* rom_style = "distributed", ram_style = "distributed" *)
    logic [DATA_BITS-1:0] mem_q [DEPTH];

    // table write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/logicnet_lut_layer.sv
// Layer of runtime-writable truth-table neurons with a pipelined valid/ready lookup path
// and a sweep that zeroes every table after reset or on request.
module logicnet_lut_layer
    import logicnet_pkg::*;
#(
    parameter int N_NEURONS   = 8,
    parameter int IN_BITS     = 6,
    parameter int OUT_BITS    = 1,
    parameter int PIPE_STAGES = 1
) (
    input logic                 clk,
    input logic                 rst,
    logicnet_lut_layer_if.slave bus
);

    localparam int DW = N_NEURONS * OUT_BITS;
    localparam int NW = sel_width(N_NEURONS);

    lut_state_e                      state_q;
    logic [IN_BITS-1:0]              clr_cnt_q;
    logic                            busy_q;
    logic                            run_q;

    logic [PIPE_STAGES-1:0]          valid_q;
    logic [PIPE_STAGES-1:0][DW-1:0]  data_q;
    logic [PIPE_STAGES-1:0]          adv_s;
    logic [PIPE_STAGES:0]            chain_valid_s;
    logic [PIPE_STAGES:0][DW-1:0]    chain_data_s;

    logic [DW-1:0]                   lookup_s;
    logic                            accept_s;
    logic                            clearing_s;
    logic                            cfg_wr_s;
    logic [IN_BITS-1:0]              waddr_s;
    logic [OUT_BITS-1:0]             wdata_s;

    // clear/run state machine; busy and run flags are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
            run_q     <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == {IN_BITS{1'b1}}) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                        run_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.cfg_clear) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        run_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_cnt_q <= '0;
                    busy_q    <= 1'b1;
                    run_q     <= 1'b0;
                end
            endcase
        end
    end

    // a stage may load when it is empty or the stage after it moves this cycle
    always_comb begin
        logic down_s;
        adv_s  = '0;
        down_s = bus.out_ready;
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            adv_s[s] = ~valid_q[s] | down_s;
            down_s   = adv_s[s];
        end
    end

    assign accept_s      = bus.in_valid & bus.in_ready;
    assign chain_valid_s = {valid_q, accept_s};
    assign chain_data_s  = {data_q, lookup_s};

    // sweep writes zeros to every table; table writes share one address/data bus
    assign clearing_s = (state_q == CLEAR);
    assign cfg_wr_s   = run_q & bus.cfg_valid & ~bus.cfg_clear;
    assign waddr_s    = clearing_s ? clr_cnt_q : bus.cfg_addr;
    assign wdata_s    = clearing_s ? {OUT_BITS{1'b0}} : bus.cfg_data;

    for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
        logic we_s;
        assign we_s = clearing_s | (cfg_wr_s & (bus.cfg_neuron == NW'(n)));

        logicnet_lut_ram #(
            .ADDR_BITS (IN_BITS),
            .DATA_BITS (OUT_BITS)
        ) u_ram (
            .clk_i   (clk),
            .we_i    (we_s),
            .waddr_i (waddr_s),
            .wdata_i (wdata_s),
            .raddr_i (bus.in_data[n*IN_BITS +: IN_BITS]),
            .rdata_o (lookup_s[n*OUT_BITS +: OUT_BITS])
        );
    end

    // lookup pipeline; data only reloads when a valid beat enters the stage
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                if (adv_s[s]) begin
                    valid_q[s] <= chain_valid_s[s];
                    if (chain_valid_s[s]) begin
                        data_q[s] <= chain_data_s[s];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = run_q & adv_s[0];
    assign bus.out_valid = valid_q[PIPE_STAGES-1];
    assign bus.out_data  = data_q[PIPE_STAGES-1];
    assign bus.cfg_ready = run_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_logicnet_lut_layer.sv
// Directed and streaming checks of logicnet_lut_layer against a table/queue model.
module tb_logicnet_lut_layer;

    localparam int N     = 8;
    localparam int IB    = 6;
    localparam int OB    = 1;
    localparam int PS    = 2;
    localparam int DW    = N * OB;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logicnet_lut_layer_if #(.N_NEURONS(N), .IN_BITS(IB), .OUT_BITS(OB)) bus ();

    logicnet_lut_layer #(
        .N_NEURONS   (N),
        .IN_BITS     (IB),
        .OUT_BITS    (OB),
        .PIPE_STAGES (PS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } beat_t;

    logic [OB-1:0] tbl [N][DEPTH];
    beat_t         exp_q[$];
    logic [DW-1:0] got_q[$];
    int            clear_left = 0;
    int            cyc = 0;

    function automatic logic [DW-1:0] model_lookup(input logic [N*IB-1:0] a);
        logic [DW-1:0] r;
        for (int n = 0; n < N; n++) begin
            r[n*OB +: OB] = tbl[n][a[n*IB +: IB]];
        end
        return r;
    endfunction

    always @(negedge clk) begin : compare
        logic  run;
        logic  exp_ir;
        logic  exp_ov;
        beat_t b;
        if (rst) begin
            exp_q.delete();
            clear_left = DEPTH;
            for (int n = 0; n < N; n++)
                for (int a = 0; a < DEPTH; a++)
                    tbl[n][a] = '0;
        end else begin
            run    = (clear_left == 0);
            exp_ov = (exp_q.size() > 0) && (cyc >= exp_q[0].t + PS);
            exp_ir = run && ((exp_q.size() < PS) || bus.out_ready);
            chk("busy", bus.busy, !run);
            chk("cfg_ready", bus.cfg_ready, run);
            chk("in_ready", bus.in_ready, exp_ir);
            chk("out_valid", bus.out_valid, exp_ov);
            if (exp_ov) begin
                chk("out_data", bus.out_data, exp_q[0].d);
                if (bus.out_ready) begin
                    got_q.push_back(bus.out_data);
                    void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && exp_ir) begin
                b.d = model_lookup(bus.in_data);
                b.t = cyc;
                exp_q.push_back(b);
            end
            if (!run) begin
                clear_left--;
            end else if (bus.cfg_clear) begin
                clear_left = DEPTH;
                for (int n = 0; n < N; n++)
                    for (int a = 0; a < DEPTH; a++)
                        tbl[n][a] = '0;
            end else if (bus.cfg_valid && bus.cfg_neuron < N) begin
                tbl[bus.cfg_neuron][bus.cfg_addr] = bus.cfg_data;
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N*IB-1:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) timeout("send");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic cfg_wr(input logic [2:0] nr, input logic [IB-1:0] a, input logic [OB-1:0] d);
        bus.cfg_valid  = 1'b1;
        bus.cfg_neuron = nr;
        bus.cfg_addr   = a;
        bus.cfg_data   = d;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic expect_out(input logic [DW-1:0] exp, input string name);
        int n = 0;
        while (got_q.size() == 0 && n < 200) begin
            tick();
            n++;
        end
        if (got_q.size() == 0) timeout(name);
        else chk(name, got_q.pop_front(), exp);
    endtask

    task automatic count_to_ready(output int n);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           n;
        logic         acc;
        logic [63:0]  rnd;

        bus.in_valid   = 1'b1;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        bus.cfg_valid  = 1'b0;
        bus.cfg_neuron = '0;
        bus.cfg_addr   = '0;
        bus.cfg_data   = '0;
        bus.cfg_clear  = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 8'h00);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_cfg_ready", bus.cfg_ready, 1'b0);
        chk("rst_busy", bus.busy, 1'b1);
        tick();
        rst = 1'b0;

        // CLEAR lasts 64 cycles while in_valid is held
        count_to_ready(n);
        chk("first_ready_cycle", n, 64);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) tick();
        got_q.delete();

        send({N{6'h00}});
        send({N{6'h15}});
        send({N{6'h3F}});
        expect_out(8'h00, "zero_00");
        expect_out(8'h00, "zero_15");
        expect_out(8'h00, "zero_3f");

        // single programmed entry, latency PIPE_STAGES
        cfg_wr(3'd3, 6'h2A, 1'b1);
        send({N{6'h2A}});
        repeat (PS - 1) @(posedge clk);
        @(negedge clk);
        chk("n3_latency_valid", bus.out_valid, 1'b1);
        chk("n3_data", bus.out_data, 8'b0000_1000);
        tick();
        repeat (4) tick();
        got_q.delete();

        // write and lookup of the same entry in one cycle
        bus.cfg_valid  = 1'b1;
        bus.cfg_neuron = 3'd0;
        bus.cfg_addr   = 6'h05;
        bus.cfg_data   = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = {N{6'h05}};
        tick();
        bus.cfg_valid = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        expect_out(8'h00, "collide_old");
        expect_out(8'h01, "collide_new");
        repeat (4) tick();

        // random tables, then 100 beats with random backpressure
        for (int i = 0; i < 60; i++) begin
            cfg_wr(3'($urandom_range(0, N - 1)), 6'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)));
        end
        got_q.delete();
        for (int i = 0; i < 100; i++) begin
            rnd          = {$urandom(), $urandom()};
            bus.in_valid = 1'b1;
            bus.in_data  = rnd[N*IB-1:0];
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 500) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = bus.in_ready;
                n++;
                @(posedge clk);
                #1;
            end
            if (!acc) timeout("stream_accept");
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) tick();
        chk("stream_count", got_q.size(), 100);
        chk("stream_drained", exp_q.size(), 0);

        // clear with an in-flight beat
        for (int k = 0; k < N; k++) cfg_wr(3'(k), 6'h11, 1'b1);
        got_q.delete();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = {N{6'h11}};
        tick();
        bus.in_valid   = 1'b0;
        bus.cfg_clear  = 1'b1;
        bus.cfg_valid  = 1'b1;
        bus.cfg_neuron = 3'd1;
        bus.cfg_addr   = 6'h22;
        bus.cfg_data   = 1'b1;
        tick();
        bus.cfg_clear  = 1'b0;
        bus.cfg_neuron = 3'd2;
        bus.cfg_addr   = 6'h33;
        bus.out_ready  = 1'b1;
        repeat (3) tick();
        bus.cfg_valid = 1'b0;
        bus.cfg_clear = 1'b1;
        tick();
        bus.cfg_clear = 1'b0;
        n = 4;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("clear_len", n, 64);
        tick();
        expect_out(8'hFF, "drain_old");
        send({N{6'h11}});
        send({N{6'h33}});
        send({N{6'h2A}});
        expect_out(8'h00, "cleared_11");
        expect_out(8'h00, "cleared_33");
        expect_out(8'h00, "cleared_2a");
        repeat (4) tick();

        // reset with two beats held
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = {N{6'h3F}};
        tick();
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", bus.in_ready, 1'b0);
        chk("full_out_valid", bus.out_valid, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst2_out_valid", bus.out_valid, 1'b0);
        chk("rst2_busy", bus.busy, 1'b1);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        count_to_ready(n);
        chk("restart_clear_len", n, 64);
        tick();
        got_q.delete();
        send({N{6'h2A}});
        expect_out(8'h00, "post_rst_2a");
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
